// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    // Hazard sequencer states: normal issue, or waiting on data memory
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // EXE operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Hard-wired zero register; never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/src_match.sv
// Single source-vs-destination dependency comparator for the hazard sequencer.
module src_match
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  logic       valid,
    input  logic [4:0] dest,
    input  logic       wb_en,
    output logic       match
);

    assign match = valid && src_used && wb_en && (dest == src) && (src != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer for the 5-stage MIPS core.
// Compares ID sources against EXE/MEM destinations, tracks the data-memory
// handshake and drives freeze/bubble/flush/hold and forwarding selects.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding; without
// it every EXE/MEM dependency stalls and the forwarding selects are tied to 00.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_src2_used,
    input  logic             br_taken,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze,
    output logic             bubble,
    output logic             flush,
    output logic             hold_all,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t            state_q, state_d;
    logic              m1_exe, m1_mem, m2_exe, m2_mem;
    logic              hazard;
    logic              mem_stall;
    logic [CNT_W-1:0]  stall_q;

    src_match u_m1_exe (
        .src      (id_src1),
        .src_used (1'b1),
        .valid    (id_valid),
        .dest     (exe_dest),
        .wb_en    (exe_wb_en),
        .match    (m1_exe)
    );

    src_match u_m1_mem (
        .src      (id_src1),
        .src_used (1'b1),
        .valid    (id_valid),
        .dest     (mem_dest),
        .wb_en    (mem_wb_en),
        .match    (m1_mem)
    );

    src_match u_m2_exe (
        .src      (id_src2),
        .src_used (id_src2_used),
        .valid    (id_valid),
        .dest     (exe_dest),
        .wb_en    (exe_wb_en),
        .match    (m2_exe)
    );

    src_match u_m2_mem (
        .src      (id_src2),
        .src_used (id_src2_used),
        .valid    (id_valid),
        .dest     (mem_dest),
        .wb_en    (mem_wb_en),
        .match    (m2_mem)
    );

`ifdef HAZARD_FORWARD_EN
    // Only a load still in EXE cannot be forwarded in time
    assign hazard = exe_mem_r_en && (m1_exe || m2_exe);
`else
    logic unused_mem_r_en;
    assign unused_mem_r_en = exe_mem_r_en;
    assign hazard = m1_exe || m1_mem || m2_exe || m2_mem;
`endif

    // Stall on a waiting access, including the RUN cycle that starts it
    assign mem_stall = (state_q == MEM_WAIT) || (mem_req && !mem_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave RUN on an unfinished access, return on first ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_ready)             state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Control outputs: memory wait > data hazard > taken branch
    always_comb begin
        freeze   = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        hold_all = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                hold_all = 1'b1;
                freeze   = 1'b1;
            end else if (hazard) begin
                freeze = 1'b1;
                bubble = 1'b1;
            end else if (br_taken) begin
                flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic [1:0] sel1_q, sel2_q;

    // Forwarding selects follow the ID instruction into EXE; a bubble carries no operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1_q <= FWD_REG;
            sel2_q <= FWD_REG;
        end else if (bubble) begin
            sel1_q <= FWD_REG;
            sel2_q <= FWD_REG;
        end else if (!freeze && !hold_all) begin
            sel1_q <= m1_exe ? FWD_EXE : (m1_mem ? FWD_MEM : FWD_REG);
            sel2_q <= m2_exe ? FWD_EXE : (m2_mem ? FWD_MEM : FWD_REG);
        end
    end

    assign fwd_sel1 = sel1_q;
    assign fwd_sel2 = sel2_q;
`else
    assign fwd_sel1 = FWD_REG;
    assign fwd_sel2 = FWD_REG;
`endif

    // Saturating count of frozen cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (freeze && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;

endmodule
